// File: rtl/hardcloud_top_example_ap_ctrl.sv
// Kernel control sequencer for the vadd datapath.
// Speaks ap_ctrl_hs towards the host control registers, snapshots the run
// arguments, pulses core_start once, waits for core_done (or the watchdog)
// and reports ap_done plus run statistics.
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   ap_start/ap_ready/ap_idle/ap_done   host handshake
//   cfg_*                       run arguments from control registers
//   core_start, core_*          start pulse and argument snapshot to datapath
//   core_done                   completion pulse from write master
//   stat_cycles/timeout/err     busy cycle count, watchdog abort, stray done
module hardcloud_top_example_ap_ctrl #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned C_CONST_WIDTH     = 32,
    parameter int unsigned C_CNT_WIDTH       = 32,
    parameter int unsigned C_TIMEOUT_CYCLES  = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic [C_ADDR_WIDTH-1:0]      cfg_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] cfg_xfer_size,
    input  logic [C_CONST_WIDTH-1:0]     cfg_constant,
    output logic                         core_start,
    output logic [C_ADDR_WIDTH-1:0]      core_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] core_xfer_size,
    output logic [C_CONST_WIDTH-1:0]     core_constant,
    input  logic                         core_done,
    output logic [C_CNT_WIDTH-1:0]       stat_cycles,
    output logic                         stat_timeout,
    output logic                         stat_err
);

    localparam logic [C_CNT_WIDTH-1:0] TIMEOUT_LIMIT = C_CNT_WIDTH'(C_TIMEOUT_CYCLES);
    localparam bit                     TIMEOUT_EN    = (C_TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic                         ap_ready_d, ap_idle_d, ap_done_d, core_start_d;
    logic [C_ADDR_WIDTH-1:0]      addr_d;
    logic [C_XFER_SIZE_WIDTH-1:0] size_d;
    logic [C_CONST_WIDTH-1:0]     const_d;
    logic [C_CNT_WIDTH-1:0]       cycles_d, cnt_inc;
    logic                         timeout_d, err_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state_q;
        ap_ready_d   = 1'b0;
        core_start_d = 1'b0;
        addr_d       = core_addr_offset;
        size_d       = core_xfer_size;
        const_d      = core_constant;
        cycles_d     = stat_cycles;
        timeout_d    = stat_timeout;
        err_d        = stat_err;
        cnt_inc      = (stat_cycles == {C_CNT_WIDTH{1'b1}}) ? stat_cycles
                                                            : stat_cycles + C_CNT_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    addr_d       = cfg_addr_offset;
                    size_d       = cfg_xfer_size;
                    const_d      = cfg_constant;
                    cycles_d     = '0;
                    timeout_d    = 1'b0;
                    err_d        = 1'b0;
                    ap_ready_d   = 1'b1;
                    core_start_d = (cfg_xfer_size != '0);
                    state_d      = S_START;
                end
            end
            // Zero-size runs spend this cycle without core_start and finish directly.
            S_START: state_d = (core_xfer_size == '0) ? S_DONE : S_BUSY;
            S_BUSY: begin
                cycles_d = cnt_inc;
                if (core_done) begin
                    state_d = S_DONE;
                end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_LIMIT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A completion pulse outside a run is a protocol error.
        if (core_done && (state_q != S_BUSY)) begin
            err_d = 1'b1;
        end

        ap_done_d = (state_d == S_DONE);
        ap_idle_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q          <= S_IDLE;
            ap_ready         <= 1'b0;
            ap_idle          <= 1'b1;
            ap_done          <= 1'b0;
            core_start       <= 1'b0;
            core_addr_offset <= '0;
            core_xfer_size   <= '0;
            core_constant    <= '0;
            stat_cycles      <= '0;
            stat_timeout     <= 1'b0;
            stat_err         <= 1'b0;
        end else begin
            state_q          <= state_d;
            ap_ready         <= ap_ready_d;
            ap_idle          <= ap_idle_d;
            ap_done          <= ap_done_d;
            core_start       <= core_start_d;
            core_addr_offset <= addr_d;
            core_xfer_size   <= size_d;
            core_constant    <= const_d;
            stat_cycles      <= cycles_d;
            stat_timeout     <= timeout_d;
            stat_err         <= err_d;
        end
    end

endmodule

// File: tb/tb_hardcloud_top_example_ap_ctrl.sv
// Self-checking bench for hardcloud_top_example_ap_ctrl.
// Instance a has no watchdog; instance b uses a 16-cycle watchdog.
module tb_hardcloud_top_example_ap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0, ap_start_b = 1'b0;
    logic        core_done = 1'b0, core_done_b = 1'b0;
    logic [63:0] cfg_addr = '0;
    logic [31:0] cfg_size = '0, cfg_const = '0;

    logic        ap_ready, ap_idle, ap_done, core_start;
    logic [63:0] core_addr;
    logic [31:0] core_size, core_const, stat_cycles;
    logic        stat_timeout, stat_err;

    logic        ap_ready_b, ap_idle_b, ap_done_b, core_start_b;
    logic [63:0] core_addr_b;
    logic [31:0] core_size_b, core_const_b, stat_cycles_b;
    logic        stat_timeout_b, stat_err_b;

    always #5 clk = ~clk;

    hardcloud_top_example_ap_ctrl #(.C_TIMEOUT_CYCLES(0)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .cfg_addr_offset(cfg_addr),
        .cfg_xfer_size(cfg_size), .cfg_constant(cfg_const), .core_start(core_start),
        .core_addr_offset(core_addr), .core_xfer_size(core_size), .core_constant(core_const),
        .core_done(core_done), .stat_cycles(stat_cycles), .stat_timeout(stat_timeout),
        .stat_err(stat_err));

    hardcloud_top_example_ap_ctrl #(.C_TIMEOUT_CYCLES(16)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start_b), .ap_ready(ap_ready_b),
        .ap_idle(ap_idle_b), .ap_done(ap_done_b), .cfg_addr_offset(cfg_addr),
        .cfg_xfer_size(cfg_size), .cfg_constant(cfg_const), .core_start(core_start_b),
        .core_addr_offset(core_addr_b), .core_xfer_size(core_size_b), .core_constant(core_const_b),
        .core_done(core_done_b), .stat_cycles(stat_cycles_b), .stat_timeout(stat_timeout_b),
        .stat_err(stat_err_b));

    int cyc = 0;
    int ready_n = 0, start_n = 0, done_n = 0;
    int ready_cyc = 0, start_cyc = 0, done_cyc = 0;
    int done_b_n = 0, done_b_cyc = 0;
    int n_pass = 0, n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts and timestamps handshake pulses mid-cycle.
    always @(negedge clk) begin
        if (ap_ready)   begin ready_n <= ready_n + 1; ready_cyc <= cyc; end
        if (core_start) begin start_n <= start_n + 1; start_cyc <= cyc; end
        if (ap_done)    begin done_n  <= done_n + 1;  done_cyc  <= cyc; end
        if (ap_done_b)  begin done_b_n <= done_b_n + 1; done_b_cyc <= cyc; end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] size;
        logic [63:0] addr;
        logic [31:0] cst;
        int          d;
        int          exp_cycles;
        int          exp_done_lat;
        int          exp_starts;
    } vec_t;

    // Reference rules: ready and start one cycle after ap_start is sampled,
    // done after d busy cycles plus start and done-register latency.
    function automatic int model_done_lat(input logic [31:0] size, input int d);
        return (size == 0) ? 2 : d + 2;
    endfunction

    // One complete run on instance a, core_done d cycles after core_start.
    task automatic run_a(input string tag, input logic [31:0] size, input logic [63:0] addr,
                         input logic [31:0] cst, input int d, input int exp_cycles,
                         input int exp_lat, input int exp_starts);
        int n, r0, s0, d0;
        r0 = ready_n; s0 = start_n; d0 = done_n;
        cfg_size = size; cfg_addr = addr; cfg_const = cst;
        ap_start = 1'b1;
        n = cyc;
        tick();
        ap_start = 1'b0;
        check({tag, "_idle_low"}, 64'(ap_idle), 64'd0);
        check({tag, "_snap_addr"}, core_addr, addr);
        check({tag, "_snap_size"}, 64'(core_size), 64'(size));
        check({tag, "_snap_const"}, 64'(core_const), 64'(cst));
        cfg_addr = ~addr; cfg_size = ~size; cfg_const = ~cst;
        if (size != 0) begin
            repeat (d) tick();
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
        end
        for (int i = 0; i < 12 && done_n == d0; i++) tick();
        tick(); tick();
        check({tag, "_ready_cnt"}, 64'(ready_n - r0), 64'd1);
        check({tag, "_ready_lat"}, 64'(ready_cyc - n), 64'd1);
        check({tag, "_start_cnt"}, 64'(start_n - s0), 64'(exp_starts));
        if (exp_starts != 0) check({tag, "_start_lat"}, 64'(start_cyc - n), 64'd1);
        check({tag, "_done_cnt"}, 64'(done_n - d0), 64'd1);
        check({tag, "_done_lat"}, 64'(done_cyc - n), 64'(exp_lat));
        check({tag, "_cycles"}, 64'(stat_cycles), 64'(exp_cycles));
        check({tag, "_idle_end"}, 64'(ap_idle), 64'd1);
        check({tag, "_hold_addr"}, core_addr, addr);
    endtask

    vec_t vecs[4];

    initial begin
        int n, d0, s1, s2, rlat;
        logic [31:0] rs;
        int rd;

        vecs[0] = '{32'd4096, 64'h1000, 32'd5, 20, 20, 22, 1};
        vecs[1] = '{32'd0, 64'h2000, 32'd7, 0, 0, 2, 0};
        vecs[2] = '{32'd64, 64'hDEAD_BEEF_0000_0040, 32'hFFFF_FFFF, 1, 1, 3, 1};
        vecs[3] = '{32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 9, 9, 11, 1};

        // Reset state.
        #12;
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_ready", 64'(ap_ready), 64'd0);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_addr", core_addr, 64'd0);
        check("rst_cycles", 64'(stat_cycles), 64'd0);
        check("rst_err", 64'(stat_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 4; i++)
            run_a($sformatf("vec%0d", i), vecs[i].size, vecs[i].addr, vecs[i].cst,
                  vecs[i].d, vecs[i].exp_cycles, vecs[i].exp_done_lat, vecs[i].exp_starts);

        // Randomized runs against the reference rules.
        for (int i = 0; i < 12; i++) begin
            rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rd = $urandom_range(1, 30);
            rlat = model_done_lat(rs, rd);
            run_a($sformatf("rnd%0d", i), rs, {$urandom, $urandom}, $urandom, rd,
                  (rs == 0) ? 0 : rd, rlat, (rs == 0) ? 0 : 1);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Back-to-back runs with ap_start held and cfg changed mid-run.
        cfg_size = 32'd128; cfg_addr = 64'hA000; cfg_const = 32'd11;
        ap_start = 1'b1;
        for (int i = 0; i < 10 && !core_start; i++) tick();
        check("b2b_start1_seen", 64'(core_start), 64'd1);
        s1 = cyc;
        check("b2b_snap1_addr", core_addr, 64'hA000);
        cfg_size = 32'd256; cfg_addr = 64'hB000; cfg_const = 32'd22;
        repeat (5) tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        for (int i = 0; i < 12 && !core_start; i++) tick();
        check("b2b_start2_seen", 64'(core_start), 64'd1);
        s2 = cyc;
        ap_start = 1'b0;
        check("b2b_period", 64'(s2 - s1), 64'd8);
        check("b2b_snap2_addr", core_addr, 64'hB000);
        check("b2b_snap2_size", 64'(core_size), 64'd256);
        check("b2b_snap2_const", 64'(core_const), 64'd22);
        repeat (5) tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        repeat (3) tick();
        check("b2b_cycles", 64'(stat_cycles), 64'd5);
        check("b2b_idle", 64'(ap_idle), 64'd1);

        // Stray core_done while idle.
        d0 = done_n; n = start_n;
        core_done = 1'b1; tick(); core_done = 1'b0;
        tick(); tick();
        check("stray_err", 64'(stat_err), 64'd1);
        check("stray_idle", 64'(ap_idle), 64'd1);
        check("stray_no_done", 64'(done_n - d0), 64'd0);
        check("stray_no_start", 64'(start_n - n), 64'd0);
        cfg_size = 32'd8; ap_start = 1'b1; tick(); ap_start = 1'b0;
        check("stray_err_cleared", 64'(stat_err), 64'd0);
        repeat (2) tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        repeat (3) tick();

        // Watchdog on instance b.
        cfg_size = 32'd64;
        d0 = done_b_n;
        ap_start_b = 1'b1; n = cyc; tick(); ap_start_b = 1'b0;
        for (int i = 0; i < 40 && done_b_n == d0; i++) tick();
        check("wd_done_cnt", 64'(done_b_n - d0), 64'd1);
        check("wd_done_lat", 64'(done_b_cyc - n), 64'd18);
        check("wd_timeout", 64'(stat_timeout_b), 64'd1);
        check("wd_cycles", 64'(stat_cycles_b), 64'd16);
        tick(); tick();
        ap_start_b = 1'b1; tick(); ap_start_b = 1'b0;
        check("wd_rerun_ready", 64'(ap_ready_b), 64'd1);
        check("wd_timeout_cleared", 64'(stat_timeout_b), 64'd0);
        repeat (3) tick();
        core_done_b = 1'b1; tick(); core_done_b = 1'b0;
        tick(); tick();
        check("wd_short_timeout", 64'(stat_timeout_b), 64'd0);
        check("wd_short_cycles", 64'(stat_cycles_b), 64'd3);
        // core_done exactly on the limit cycle: normal completion wins.
        ap_start_b = 1'b1; tick(); ap_start_b = 1'b0;
        repeat (16) tick();
        core_done_b = 1'b1; tick(); core_done_b = 1'b0;
        tick(); tick();
        check("wd_tie_timeout", 64'(stat_timeout_b), 64'd0);
        check("wd_tie_cycles", 64'(stat_cycles_b), 64'd16);
        check("wd_tie_err", 64'(stat_err_b), 64'd0);

        // Reset asserted mid-BUSY.
        cfg_size = 32'd100; cfg_addr = 64'h3000;
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_idle", 64'(ap_idle), 64'd1);
        check("mrst_cycles", 64'(stat_cycles), 64'd0);
        check("mrst_addr", core_addr, 64'd0);
        check("mrst_size", 64'(core_size), 64'd0);
        tick();
        rst_n = 1'b1;
        d0 = done_n;
        repeat (5) tick();
        check("mrst_no_done", 64'(done_n - d0), 64'd0);
        check("mrst_idle_after", 64'(ap_idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
